// File: rtl/pong_input_conditioner_if.sv
// Player-input bundle between the raw button/ball-position sources and the input conditioner.
// The master side drives the raw buttons and AI inputs; the slave side returns conditioned controls.
interface pong_input_conditioner_if;
  logic       btn_up_p1_n;
  logic       btn_down_p1_n;
  logic       btn_up_p2_n;
  logic       btn_down_p2_n;
  logic [9:0] sq_ypos;
  logic [9:0] pdl2_ypos;
  logic       sq_shown;
  logic       ai_enable;
  logic       up_p1;
  logic       down_p1;
  logic       up_p2;
  logic       down_p2;
  logic       any_press;

  modport master (
    output btn_up_p1_n, btn_down_p1_n, btn_up_p2_n, btn_down_p2_n,
    output sq_ypos, pdl2_ypos, sq_shown, ai_enable,
    input  up_p1, down_p1, up_p2, down_p2, any_press
  );

  modport slave (
    input  btn_up_p1_n, btn_down_p1_n, btn_up_p2_n, btn_down_p2_n,
    input  sq_ypos, pdl2_ypos, sq_shown, ai_enable,
    output up_p1, down_p1, up_p2, down_p2, any_press
  );
endinterface

// File: rtl/pong_input_conditioner.sv
// Synchronises and debounces four raw player buttons, cancels opposing presses, pulses any_press.
// Define AI_P2_EN to build the ball-tracking driver that can replace player 2's buttons.
module pong_input_conditioner #(
  parameter int unsigned CLK_HZ          = 25_175_000,
  parameter int unsigned DEBOUNCE_MS     = 10,
  parameter int unsigned PDL_HEIGHT      = 96,
  parameter int unsigned SQ_WIDTH        = 16,
  parameter int unsigned AI_DEADBAND     = 8,
  parameter int unsigned AI_REACT_CYCLES = 1_000_000
) (
  input  logic                     clk_0,
  input  logic                     rst,
  pong_input_conditioner_if.slave  bus
);

  localparam int unsigned N    = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned CntW = $clog2(N + 1);

  // Channel order: 0 up_p1, 1 down_p1, 2 up_p2, 3 down_p2.
  logic [3:0]      raw;
  logic [3:0]      s1_q, s2_q;
  logic [3:0]      db_q, db_d;
  logic [3:0]      db_dly_q;
  logic [CntW-1:0] cnt_q [4];
  logic [CntW-1:0] cnt_d [4];
  logic            any_press_q, any_press_d;
  logic            p1_up, p1_dn, p2_up, p2_dn;

  assign raw = ~{bus.btn_down_p2_n, bus.btn_up_p2_n, bus.btn_down_p1_n, bus.btn_up_p1_n};

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      db_q        <= '0;
      db_dly_q    <= '0;
      any_press_q <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      s1_q        <= raw;
      s2_q        <= s1_q;
      db_q        <= db_d;
      db_dly_q    <= db_q;
      any_press_q <= any_press_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A channel flips only after N consecutive samples disagreeing with its debounced level.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CntW'(N - 1)) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Pre-cancel rise detect: one pulse even when several channels rise together.
  assign any_press_d = |(db_q & ~db_dly_q);

  assign p1_up = db_q[0] & ~db_q[1];
  assign p1_dn = db_q[1] & ~db_q[0];
  assign p2_up = db_q[2] & ~db_q[3];
  assign p2_dn = db_q[3] & ~db_q[2];

  assign bus.up_p1     = p1_up;
  assign bus.down_p1   = p1_dn;
  assign bus.any_press = any_press_q;

`ifdef AI_P2_EN
  localparam int unsigned AiW = (AI_REACT_CYCLES > 1) ? $clog2(AI_REACT_CYCLES) : 1;

  logic [AiW-1:0] ai_cnt_q, ai_cnt_d;
  logic           ai_en_q;
  logic           ai_up_q, ai_up_d;
  logic           ai_dn_q, ai_dn_d;
  logic [10:0]    bc, pc;
  logic           want_up, want_dn;

  assign bc      = 11'(bus.sq_ypos) + 11'(SQ_WIDTH / 2);
  assign pc      = 11'(bus.pdl2_ypos) + 11'(PDL_HEIGHT / 2);
  assign want_up = bus.sq_shown && ((bc + 11'(AI_DEADBAND)) < pc);
  assign want_dn = bus.sq_shown && (bc > (pc + 11'(AI_DEADBAND)));

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      ai_cnt_q <= '0;
      ai_en_q  <= 1'b0;
      ai_up_q  <= 1'b0;
      ai_dn_q  <= 1'b0;
    end else begin
      ai_cnt_q <= ai_cnt_d;
      ai_en_q  <= bus.ai_enable;
      ai_up_q  <= ai_up_d;
      ai_dn_q  <= ai_dn_d;
    end
  end

  // While disabled the tracker is held cleared, so enabling starts a fresh period with no command.
  always_comb begin
    ai_cnt_d = ai_cnt_q;
    ai_up_d  = ai_up_q;
    ai_dn_d  = ai_dn_q;
    if (!bus.ai_enable) begin
      ai_cnt_d = '0;
      ai_up_d  = 1'b0;
      ai_dn_d  = 1'b0;
    end else if (ai_cnt_q == AiW'(AI_REACT_CYCLES - 1)) begin
      ai_cnt_d = '0;
      ai_up_d  = want_up;
      ai_dn_d  = want_dn;
    end else begin
      ai_cnt_d = ai_cnt_q + AiW'(1);
    end
  end

  assign bus.up_p2   = ai_en_q ? ai_up_q : p2_up;
  assign bus.down_p2 = ai_en_q ? ai_dn_q : p2_dn;
`else
  logic unused_ai;
  assign unused_ai   = ^{bus.sq_ypos, bus.pdl2_ypos, bus.sq_shown, bus.ai_enable};
  assign bus.up_p2   = p2_up;
  assign bus.down_p2 = p2_dn;
`endif

endmodule
